// File: rtl/sparc_ifu_thrfsm_arr_pkg.sv
// sparc_ifu_thrfsm_arr_pkg: thread FSM state encodings and state classification helpers
package sparc_ifu_thrfsm_arr_pkg;
  localparam logic [4:0] THRFSM_IDLE     = 5'b00000;
  localparam logic [4:0] THRFSM_HALT     = 5'b00010;
  localparam logic [4:0] THRFSM_WAIT     = 5'b00001;
  localparam logic [4:0] THRFSM_RDY      = 5'b11001;
  localparam logic [4:0] THRFSM_RUN      = 5'b00101;
  localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
  localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;
  localparam int TCR_READY = 4;

  function automatic logic is_rdy(input logic [4:0] s);
    return (s == THRFSM_RDY) || (s == THRFSM_SPEC_RDY);
  endfunction

  function automatic logic is_run(input logic [4:0] s);
    return (s == THRFSM_RUN) || (s == THRFSM_SPEC_RUN);
  endfunction
endpackage

// File: rtl/sparc_ifu_thrfsm_arr_nxt.sv
// sparc_ifu_thrfsm_nxt: combinational next-state function of one thread FSM
module sparc_ifu_thrfsm_nxt
  import sparc_ifu_thrfsm_arr_pkg::*;
(
  input  logic [4:0] state_i,
  input  logic       completion_i,
  input  logic       spec_ld_i,
  input  logic       ldhit_i,
  input  logic       stall_i,
  input  logic       int_activate_i,
  input  logic       halt_thread_i,
  input  logic       start_thread_i,
  input  logic       nuke_thread_i,
  input  logic       thaw_thread_i,
  input  logic       rst_thread_i,
  input  logic       switch_out_i,
  input  logic       sw_cond_i,
  input  logic       schedule_i,
  output logic [4:0] nxt_o
);
  // priority-ordered transitions; invalid encodings recover via rst or nuke
  always_comb begin
    nxt_o = state_i;
    case (state_i)
      THRFSM_IDLE:     nxt_o = (rst_thread_i | thaw_thread_i) ? THRFSM_WAIT :
                               start_thread_i ? THRFSM_RDY : state_i;
      THRFSM_HALT:     nxt_o = nuke_thread_i ? THRFSM_IDLE :
                               (rst_thread_i | thaw_thread_i) ? THRFSM_WAIT :
                               (int_activate_i | start_thread_i) ? THRFSM_RDY : state_i;
      THRFSM_RDY:      nxt_o = stall_i ? THRFSM_WAIT : schedule_i ? THRFSM_RUN : state_i;
      THRFSM_RUN:      nxt_o = (stall_i | sw_cond_i) ? THRFSM_WAIT :
                               switch_out_i ? THRFSM_RDY : state_i;
      THRFSM_WAIT:     nxt_o = nuke_thread_i ? THRFSM_IDLE :
                               halt_thread_i ? THRFSM_HALT :
                               stall_i ? THRFSM_WAIT :
                               spec_ld_i ? THRFSM_SPEC_RDY :
                               completion_i ? THRFSM_RDY : state_i;
      THRFSM_SPEC_RDY: nxt_o = stall_i ? THRFSM_WAIT :
                               schedule_i ? (ldhit_i ? THRFSM_RUN : THRFSM_SPEC_RUN) :
                               ldhit_i ? THRFSM_RDY : state_i;
      THRFSM_SPEC_RUN: nxt_o = (stall_i | sw_cond_i) ? THRFSM_WAIT :
                               ldhit_i ? (switch_out_i ? THRFSM_RDY : THRFSM_RUN) :
                               switch_out_i ? THRFSM_SPEC_RDY : state_i;
      default:         nxt_o = rst_thread_i ? THRFSM_WAIT :
                               nuke_thread_i ? THRFSM_IDLE : state_i;
    endcase
  end
endmodule

// File: rtl/sparc_ifu_thrfsm_arr.sv
// sparc_ifu_thrfsm_arr: NTHR thread FSMs, round-robin switch-in scheduler, optional WAIT watchdog (SPARC_IFU_THRFSM_WDOG_EN)
module sparc_ifu_thrfsm_arr
  import sparc_ifu_thrfsm_arr_pkg::*;
#(
  parameter int NTHR   = 4,
  parameter int WDOG_W = 10
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [NTHR-1:0]   completion,
  input  logic [NTHR-1:0]   spec_ld,
  input  logic [NTHR-1:0]   ldhit,
  input  logic [NTHR-1:0]   stall,
  input  logic [NTHR-1:0]   int_activate,
  input  logic [NTHR-1:0]   halt_thread,
  input  logic [NTHR-1:0]   start_thread,
  input  logic [NTHR-1:0]   nuke_thread,
  input  logic [NTHR-1:0]   thaw_thread,
  input  logic [NTHR-1:0]   rst_thread,
  input  logic              switch_out,
  input  logic              sw_cond,
  input  logic              sched_hold,
  output logic [5*NTHR-1:0] thr_state,
  output logic [NTHR-1:0]   rdy_mask,
  output logic [NTHR-1:0]   run_mask,
  output logic [NTHR-1:0]   schedule,
  output logic [NTHR-1:0]   wdog_expire
);
  localparam int PW = (NTHR > 1) ? $clog2(NTHR) : 1;

  logic [4:0]    state_q [NTHR];
  logic [4:0]    state_d [NTHR];
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic          elig;
  logic [NTHR-1:0] cand;

  genvar i;
  for (i = 0; i < NTHR; i++) begin : g_thr
    sparc_ifu_thrfsm_nxt u_nxt (
      .state_i        (state_q[i]),
      .completion_i   (completion[i]),
      .spec_ld_i      (spec_ld[i]),
      .ldhit_i        (ldhit[i]),
      .stall_i        (stall[i]),
      .int_activate_i (int_activate[i]),
      .halt_thread_i  (halt_thread[i]),
      .start_thread_i (start_thread[i]),
      .nuke_thread_i  (nuke_thread[i]),
      .thaw_thread_i  (thaw_thread[i]),
      .rst_thread_i   (rst_thread[i]),
      .switch_out_i   (switch_out),
      .sw_cond_i      (sw_cond),
      .schedule_i     (schedule[i]),
      .nxt_o          (state_d[i])
    );
    assign thr_state[5*i +: 5] = state_q[i];
    assign rdy_mask[i]         = is_rdy(state_q[i]);
    assign run_mask[i]         = is_run(state_q[i]);
  end

  assign elig = !sched_hold &&
                ((run_mask == '0) || |(run_mask & (stall | {NTHR{switch_out | sw_cond}})));
  assign cand = rdy_mask & ~stall;

  // round-robin search from ptr+1, first eligible candidate wins
  always_comb begin
    schedule = '0;
    ptr_d    = ptr_q;
    idx      = ptr_q;
    for (int k = 0; k < NTHR; k++) begin
      idx = (idx == PW'(NTHR-1)) ? '0 : idx + 1'b1;
      if (elig && cand[idx] && schedule == '0) begin
        schedule[idx] = 1'b1;
        ptr_d         = idx;
      end
    end
  end

  // thread state and pointer flops; reset leaves thread 0 first in line
  always_ff @(posedge clk) begin
    ptr_q <= !rst_l ? PW'(NTHR-1) : ptr_d;
    for (int j = 0; j < NTHR; j++)
      state_q[j] <= !rst_l ? THRFSM_IDLE : state_d[j];
  end

`ifdef SPARC_IFU_THRFSM_WDOG_EN
  logic [WDOG_W-1:0] wcnt_q [NTHR];
  logic [NTHR-1:0]   wexp_q;

  // count cycles spent in WAIT; all-ones fires a one-cycle pulse and restarts
  always_ff @(posedge clk) begin
    for (int j = 0; j < NTHR; j++) begin
      if (!rst_l) begin
        wcnt_q[j] <= '0;
        wexp_q[j] <= 1'b0;
      end else begin
        wcnt_q[j] <= (state_d[j] == THRFSM_WAIT && !(&wcnt_q[j])) ? wcnt_q[j] + 1'b1 : '0;
        wexp_q[j] <= (state_q[j] == THRFSM_WAIT) && (&wcnt_q[j]);
      end
    end
  end

  assign wdog_expire = wexp_q;
`else
  assign wdog_expire = '0;
`endif
endmodule
